pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 99 +++++++++
 tb/tb_pc_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction fetch sequencer
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic [15:0] nextPC,
  input  logic        ex_done,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] PC,
  output logic [15:0] IR,
  output logic [10:0] Ins,
  output logic        ir_valid,
  output logic [15:0] retired,
  output logic        fetch_err,
  output logic        busy
);

  // Wide enough to hold MAX_WAIT-1 for any MAX_WAIT >= 1.
  localparam int WW = $clog2(MAX_WAIT) + 1;
  localparam logic [WW-1:0] LAST_WAIT = WW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_EXEC,
    S_HALTED,
    S_ERR
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;

  // Fetch/execute sequencing: the state register plus PC, IR, retire count and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      PC       <= RESET_PC;
      IR       <= '0;
      retired  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (start) state <= S_REQ;
        end
        S_REQ: begin
          if (imem_ack) begin
            // An ack on the last allowed cycle still wins over the timeout.
            IR       <= imem_rdata;
            wait_cnt <= '0;
            state    <= S_EXEC;
          end else if (wait_cnt == LAST_WAIT) begin
            wait_cnt <= '0;
            state    <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          // halt only matters at the commit point.
          if (ex_done) begin
            PC      <= nextPC;
            retired <= retired + 16'd1;
            state   <= halt ? S_HALTED : S_REQ;
          end
        end
        S_HALTED: begin
          wait_cnt <= '0;
          if (start) state <= S_REQ;
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status decodes depend on the registered state only, so no input reaches these outputs.
  assign imem_req  = (state == S_REQ);
  assign ir_valid  = (state == S_EXEC);
  assign busy      = (state == S_REQ) || (state == S_EXEC);
  assign fetch_err = (state == S_ERR);

  // Address is the PC, which is only updated on commit and therefore stable throughout REQ.
  assign imem_addr = PC;
  assign Ins       = IR[10:0];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt;
  logic [15:0] nextPC;
  logic        ex_done;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] PC;
  logic [15:0] IR;
  logic [10:0] Ins;
  logic        ir_valid;
  logic [15:0] retired;
  logic        fetch_err;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Scoreboard of fetch addresses the DUT must present, pushed when the start/commit is driven.
  logic [15:0] exp_addr_q[$];
  logic [15:0] ea;

  pc_fetch_unit #(
    .RESET_PC(16'h0000),
    .MAX_WAIT(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .halt      (halt),
    .nextPC    (nextPC),
    .ex_done   (ex_done),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .PC        (PC),
    .IR        (IR),
    .Ins       (Ins),
    .ir_valid  (ir_valid),
    .retired   (retired),
    .fetch_err (fetch_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; halt = 1'b0; ex_done = 1'b0; imem_ack = 1'b0;
    exp_addr_q.delete();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic start_fetch(input logic [15:0] pc);
    start = 1'b1;
    exp_addr_q.push_back(pc);
    cyc();
    start = 1'b0;
  endtask

  // Ack in the first REQ cycle, then commit npc on the first EXEC cycle.
  task automatic run_instr(input logic [15:0] rdata, input logic [15:0] npc, input logic hlt);
    imem_ack = 1'b1; imem_rdata = rdata;
    cyc();
    imem_ack = 1'b0;
    ex_done = 1'b1; nextPC = npc; halt = hlt;
    if (!hlt) exp_addr_q.push_back(npc);
    cyc();
    ex_done = 1'b0; halt = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++; if ({imem_req, ir_valid, busy, fetch_err} !== 4'b0000) $display("FAIL rst_flags got=%b exp=0000", {imem_req, ir_valid, busy, fetch_err}); else pass_cnt++;
    total_cnt++; if (PC !== 16'h0000) $display("FAIL rst_pc got=%h exp=0000", PC); else pass_cnt++;
    total_cnt++; if (IR !== 16'h0000) $display("FAIL rst_ir got=%h exp=0000", IR); else pass_cnt++;
    total_cnt++; if (retired !== 16'h0000) $display("FAIL rst_retired got=%h exp=0000", retired); else pass_cnt++;
    cyc();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h5A5A; ex_done = 1'b1; nextPC = 16'h0077;
    repeat (3) cyc();
    total_cnt++; if ({imem_req, busy} !== 2'b00) $display("FAIL idle_wait got=%b exp=00", {imem_req, busy}); else pass_cnt++;
    total_cnt++; if ({PC, IR} !== 32'h0) $display("FAIL idle_ignore got=%h exp=0", {PC, IR}); else pass_cnt++;
    imem_ack = 1'b0; ex_done = 1'b0;
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc;
    do_reset();
    start_fetch(16'h0000);
    exp_pc = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      ea = exp_addr_q.pop_front();
      total_cnt++; if ({imem_req, ir_valid, imem_addr} !== {2'b10, ea}) $display("FAIL seq_req%0d got=%b/%h exp=10/%h", i, {imem_req, ir_valid}, imem_addr, ea); else pass_cnt++;
      cyc();
      total_cnt++; if ({imem_req, imem_addr} !== {1'b1, ea}) $display("FAIL seq_stable%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, ea); else pass_cnt++;
      imem_ack = 1'b1; imem_rdata = 16'h1234;
      cyc();
      imem_ack = 1'b0;
      total_cnt++; if ({ir_valid, busy, imem_req, IR} !== {3'b110, 16'h1234}) $display("FAIL seq_exec%0d got=%b/%h exp=110/1234", i, {ir_valid, busy, imem_req}, IR); else pass_cnt++;
      ex_done = 1'b1; nextPC = exp_pc + 16'd1;
      exp_addr_q.push_back(exp_pc + 16'd1);
      cyc();
      ex_done = 1'b0;
      exp_pc = exp_pc + 16'd1;
    end
    total_cnt++; if (PC !== 16'h0005) $display("FAIL seq_pc got=%h exp=0005", PC); else pass_cnt++;
    total_cnt++; if (retired !== 16'd5) $display("FAIL seq_retired got=%0d exp=5", retired); else pass_cnt++;
    total_cnt++; if ({IR, Ins} !== {16'h1234, 11'h234}) $display("FAIL seq_ir got=%h/%h exp=1234/234", IR, Ins); else pass_cnt++;
  endtask

  task automatic test_branch();
    do_reset();
    start_fetch(16'h0000);
    run_instr(16'h0001, 16'h0001, 1'b0);
    run_instr(16'h0002, 16'h0002, 1'b0);
    run_instr(16'h0003, 16'h0003, 1'b0);
    repeat (3) void'(exp_addr_q.pop_front());
    ea = exp_addr_q.pop_front();
    total_cnt++; if (imem_addr !== ea) $display("FAIL br_pre got=%h exp=%h", imem_addr, ea); else pass_cnt++;
    imem_ack = 1'b1; imem_rdata = 16'hC003;
    cyc();
    imem_ack = 1'b0;
    ex_done = 1'b1; nextPC = 16'h0006;
    exp_addr_q.push_back(16'h0006);
    cyc();
    ex_done = 1'b0;
    ea = exp_addr_q.pop_front();
    total_cnt++; if ({imem_req, imem_addr} !== {1'b1, ea}) $display("FAIL br_target got=%b/%h exp=1/%h", imem_req, imem_addr, ea); else pass_cnt++;
  endtask

  task automatic test_jump();
    do_reset();
    start_fetch(16'h0000);
    ea = exp_addr_q.pop_front();
    total_cnt++; if ({ir_valid, imem_addr} !== {1'b0, ea}) $display("FAIL jmp_first got=%b/%h exp=0/%h", ir_valid, imem_addr, ea); else pass_cnt++;
    run_instr(16'h0100, 16'h0055, 1'b0);
    ea = exp_addr_q.pop_front();
    total_cnt++; if ({imem_req, ir_valid, PC, imem_addr} !== {2'b10, 16'h0055, ea}) $display("FAIL jmp_55 got=%b/%h/%h exp=10/0055/%h", {imem_req, ir_valid}, PC, imem_addr, ea); else pass_cnt++;
    cyc();
    total_cnt++; if (ir_valid !== 1'b0) $display("FAIL jmp_req_ivalid got=%b exp=0", ir_valid); else pass_cnt++;
    run_instr(16'h0200, 16'h0022, 1'b0);
    ea = exp_addr_q.pop_front();
    total_cnt++; if ({imem_req, ir_valid, PC, imem_addr} !== {2'b10, 16'h0022, ea}) $display("FAIL jmp_22 got=%b/%h/%h exp=10/0022/%h", {imem_req, ir_valid}, PC, imem_addr, ea); else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_reset();
    start_fetch(16'h0000);
    void'(exp_addr_q.pop_front());
    repeat (7) cyc();
    total_cnt++; if ({imem_req, fetch_err} !== 2'b10) $display("FAIL to_cycle8 got=%b exp=10", {imem_req, fetch_err}); else pass_cnt++;
    cyc();
    total_cnt++; if ({fetch_err, imem_req, ir_valid, busy} !== 4'b1000) $display("FAIL to_err got=%b exp=1000", {fetch_err, imem_req, ir_valid, busy}); else pass_cnt++;
    start = 1'b1; imem_ack = 1'b1; ex_done = 1'b1;
    repeat (2) cyc();
    start = 1'b0; imem_ack = 1'b0; ex_done = 1'b0;
    total_cnt++; if ({fetch_err, imem_req} !== 2'b10) $display("FAIL to_sticky got=%b exp=10", {fetch_err, imem_req}); else pass_cnt++;

    do_reset();
    total_cnt++; if (fetch_err !== 1'b0) $display("FAIL to_rst_clear got=%b exp=0", fetch_err); else pass_cnt++;
    start_fetch(16'h0000);
    void'(exp_addr_q.pop_front());
    repeat (7) cyc();
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    cyc();
    imem_ack = 1'b0;
    total_cnt++; if ({ir_valid, fetch_err, IR} !== {2'b10, 16'hBEEF}) $display("FAIL to_ack8 got=%b/%h exp=10/beef", {ir_valid, fetch_err}, IR); else pass_cnt++;
    ex_done = 1'b1; nextPC = 16'h0001;
    exp_addr_q.push_back(16'h0001);
    cyc();
    ex_done = 1'b0;
    ea = exp_addr_q.pop_front();
    repeat (7) cyc();
    total_cnt++; if ({imem_req, fetch_err, imem_addr} !== {2'b10, ea}) $display("FAIL to_cnt_clear got=%b/%h exp=10/%h", {imem_req, fetch_err}, imem_addr, ea); else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset();
    start_fetch(16'h0000);
    run_instr(16'h0300, 16'h0010, 1'b0);
    imem_ack = 1'b1; imem_rdata = 16'h0400;
    cyc();
    imem_ack = 1'b0;
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    total_cnt++; if ({ir_valid, PC} !== {1'b1, 16'h0010}) $display("FAIL halt_no_done got=%b/%h exp=1/0010", ir_valid, PC); else pass_cnt++;
    ex_done = 1'b1; halt = 1'b1; nextPC = 16'hAAAA;
    cyc();
    ex_done = 1'b0; halt = 1'b0;
    total_cnt++; if ({imem_req, ir_valid, busy, PC} !== {3'b000, 16'hAAAA}) $display("FAIL halt_state got=%b/%h exp=000/aaaa", {imem_req, ir_valid, busy}, PC); else pass_cnt++;
    ex_done = 1'b1; imem_ack = 1'b1; nextPC = 16'h1111;
    repeat (3) cyc();
    ex_done = 1'b0; imem_ack = 1'b0;
    total_cnt++; if ({imem_req, PC} !== {1'b0, 16'hAAAA}) $display("FAIL halt_hold got=%b/%h exp=0/aaaa", imem_req, PC); else pass_cnt++;
    exp_addr_q.delete();
    start_fetch(16'hAAAA);
    ea = exp_addr_q.pop_front();
    total_cnt++; if ({imem_req, imem_addr} !== {1'b1, ea}) $display("FAIL halt_restart got=%b/%h exp=1/%h", imem_req, imem_addr, ea); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    start_fetch(16'h0000);
    force dut.retired = 16'hFFFE;
    #1;
    release dut.retired;
    run_instr(16'h0500, 16'h0001, 1'b0);
    total_cnt++; if (retired !== 16'hFFFF) $display("FAIL wrap_ffff got=%h exp=ffff", retired); else pass_cnt++;
    run_instr(16'h0600, 16'h0002, 1'b0);
    total_cnt++; if ({retired, PC} !== {16'h0000, 16'h0002}) $display("FAIL wrap_zero got=%h/%h exp=0000/0002", retired, PC); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    start_fetch(16'h0000);
    run_instr(16'h0700, 16'h0040, 1'b0);
    void'(exp_addr_q.pop_front());
    ea = exp_addr_q.pop_front();
    total_cnt++; if ({imem_req, imem_addr} !== {1'b1, ea}) $display("FAIL ar_pre got=%b/%h exp=1/%h", imem_req, imem_addr, ea); else pass_cnt++;
    #2;
    imem_ack = 1'b1; imem_rdata = 16'hDEAD; rst = 1'b1;
    #1;
    total_cnt++; if ({imem_req, busy, PC} !== {2'b00, 16'h0000}) $display("FAIL ar_req_drop got=%b/%h exp=00/0000", {imem_req, busy}, PC); else pass_cnt++;
    cyc();
    rst = 1'b0;
    cyc();
    imem_ack = 1'b0;
    total_cnt++; if ({imem_req, ir_valid, IR, retired} !== {2'b00, 16'h0000, 16'h0000}) $display("FAIL ar_idle got=%b/%h/%h exp=00/0000/0000", {imem_req, ir_valid}, IR, retired); else pass_cnt++;
    start_fetch(16'h0000);
    imem_ack = 1'b1; imem_rdata = 16'h0800;
    cyc();
    imem_ack = 1'b0;
    #2;
    ex_done = 1'b1; nextPC = 16'h0099; rst = 1'b1;
    #1;
    total_cnt++; if ({ir_valid, busy} !== 2'b00) $display("FAIL ar_exec_drop got=%b exp=00", {ir_valid, busy}); else pass_cnt++;
    cyc();
    rst = 1'b0;
    cyc();
    ex_done = 1'b0;
    total_cnt++; if ({PC, retired} !== {16'h0000, 16'h0000}) $display("FAIL ar_no_commit got=%h/%h exp=0000/0000", PC, retired); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; nextPC = 16'h0000;
    ex_done = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_timeout();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
